// File: rtl/multdiv_pkg.sv
// Shared constants, FSM encoding and helpers for the 32-bit multiply/divide unit.
package multdiv_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement magnitude; MIN_NEG maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/multdiv_32_add_sub_33.sv
// 33-bit adder/subtractor with carry-out, shared by the multiply accumulate and the divide trial subtract.
module add_sub_33
  import multdiv_pkg::*;
(
  input  logic [DATA_W:0] a,
  input  logic [DATA_W:0] b,
  input  logic            sub,
  output logic [DATA_W:0] sum,
  output logic            cout
);

  logic [DATA_W+1:0] full;

  // In subtract mode cout=1 means no borrow, i.e. a >= b.
  assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (DATA_W+2)'(sub);
  assign sum  = full[DATA_W:0];
  assign cout = full[DATA_W+1];

endmodule

// File: rtl/multdiv_32.sv
// Iterative signed 32-bit multiplier / divider: 32 radix-2 steps on magnitudes, sign fixed at the end.
module multdiv_32
  import multdiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output logic              busy
);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   mag_a, mag_b, hi, lo;
  logic                neg, div_zero, div_ovf;
  logic                start, last;
  logic [DATA_W:0]     add_a, add_b, add_sum;
  logic                add_sub, add_cout;
  logic [2*DATA_W-1:0] prod_u, prod_s;
  logic [DATA_W-1:0]   quot_s;

  assign start = ((state == IDLE) || (state == DONE)) && (ctrl_MULT ^ ctrl_DIV);
  assign last  = (count == CNT_W'(ITER_COUNT));
  assign busy  = (state == MULT) || (state == DIV);

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) state_nxt = ctrl_MULT ? MULT : DIV;
      end
      MULT, DIV: if (last) state_nxt = DONE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Multiply: hi accumulates |A| when the multiplier LSB is set. Divide: {hi,lo[31]} minus |B|.
  always_comb begin
    add_sub = (state == DIV);
    if (state == DIV) begin
      add_a = {hi, lo[DATA_W-1]};
      add_b = {1'b0, mag_b};
    end else begin
      add_a = {1'b0, hi};
      add_b = {1'b0, mag_a};
    end
  end

  add_sub_33 u_add_sub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign prod_u = {hi, lo};
  assign prod_s = neg ? (~prod_u + 1'b1) : prod_u;
  assign quot_s = neg ? (~lo + 1'b1) : lo;

  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      mag_a          <= '0;
      mag_b          <= '0;
      hi             <= '0;
      lo             <= '0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        mag_a    <= abs_val(data_operandA);
        mag_b    <= abs_val(data_operandB);
        neg      <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == MIN_NEG) && (data_operandB == '1);
        hi       <= '0;
        lo       <= ctrl_MULT ? abs_val(data_operandB) : abs_val(data_operandA);
        count    <= '0;
      end else if (busy && !last) begin
        count <= count + 1'b1;
        if (state == MULT) begin
          if (lo[0]) begin
            hi <= add_sum[DATA_W:1];
            lo <= {add_sum[0], lo[DATA_W-1:1]};
          end else begin
            hi <= {1'b0, hi[DATA_W-1:1]};
            lo <= {hi[0], lo[DATA_W-1:1]};
          end
        end else begin
          // Restoring step: keep the trial difference only when it did not borrow.
          hi <= add_cout ? add_sum[DATA_W-1:0] : add_a[DATA_W-1:0];
          lo <= {lo[DATA_W-2:0], add_cout};
        end
      end else if (busy) begin
        data_resultRDY <= 1'b1;
        if (state == MULT) begin
          data_result    <= prod_s[DATA_W-1:0];
          data_exception <= ~((&prod_s[2*DATA_W-1:DATA_W-1]) | ~(|prod_s[2*DATA_W-1:DATA_W-1]));
        end else if (div_zero) begin
          data_result    <= '0;
          data_exception <= 1'b1;
        end else begin
          data_result    <= quot_s;
          data_exception <= div_ovf;
        end
      end
    end
  end

endmodule

// File: doc/multdiv_32.md
MULTDIV_32 -- requirements
Module: multdiv_32

Interface
REQ-001 SHALL have no parameters; width is fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_operandA  input  32  multiplicand or dividend, two's complement.
REQ-005 data_operandB  input  32  multiplier or divisor, two's complement.
REQ-006 ctrl_MULT  input  1  one-cycle pulse; start signed multiply.
REQ-007 ctrl_DIV  input  1  one-cycle pulse; start signed divide.
REQ-008 data_result  output  32  product (low 32 bits) or quotient.
REQ-009 data_exception  output  1  error flag; valid while data_resultRDY=1.
REQ-010 data_resultRDY  output  1  one-cycle result-valid strobe.
REQ-011 busy  output  1  high while an operation is in progress.

Function
REQ-012 SHALL implement the FSM states IDLE, MULT, DIV, DONE.
REQ-013 In IDLE, at an edge with exactly one of ctrl_MULT/ctrl_DIV high, operands SHALL be latched and the FSM SHALL enter MULT or DIV.
REQ-014 An edge with ctrl_MULT=ctrl_DIV=1 SHALL be ignored; the FSM SHALL stay in IDLE.
REQ-015 ctrl pulses arriving while busy=1 SHALL be ignored; latched operands SHALL not change.
REQ-016 busy SHALL be 1 in MULT and DIV, and 0 in IDLE and DONE.
REQ-017 MULT SHALL perform 32 radix-2 iterations (shift-and-add on operand magnitudes), one per cycle, using a 6-bit counter; sign SHALL be fixed up at the end.
REQ-018 DIV SHALL perform 32 iterations of restoring division on the magnitudes; quotient SHALL be truncated toward zero, with sign = signA XOR signB.
REQ-019 Latency: start accepted at edge 0; iterations run at edges 1-32; DONE entered at edge 33; data_resultRDY=1 for exactly the cycle after edge 33; the FSM SHALL return to IDLE at edge 34.
REQ-020 A new start SHALL be accepted at edge 34 or later, i.e. back-to-back operations are 34 cycles apart.
REQ-021 data_result SHALL hold its value from DONE until the next operation reaches DONE.
REQ-022 Multiply exception SHALL be 1 if the signed 64-bit product is not the sign-extension of its bit 31; data_result SHALL still be the low 32 bits.
REQ-023 Divide by zero SHALL produce data_exception=1 and data_result=0, with the full 34-cycle latency.
REQ-024 0x80000000 / -1 SHALL produce data_result=0x80000000 and data_exception=1.
REQ-025 A zero operand in multiply SHALL produce a result of 0 with exception 0.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-027 reset asserted mid-operation SHALL abort the operation with no data_resultRDY pulse.
REQ-028 reset SHALL take priority over simultaneous ctrl_MULT/ctrl_DIV.

Structure
REQ-029 Shared package multdiv_pkg SHALL hold the FSM state encoding, ITER_COUNT=32, and the DATA_W=32 constant.
REQ-030 A single sub-module add_sub_33 (33-bit adder/subtractor with carry-out) SHALL be shared by both the multiply-accumulate and the trial-subtract datapaths.
REQ-031 The design SHALL use no behavioural '*' or '/' operators.

Verification
REQ-032 MULT 7 x -6 -> data_result=0xFFFFFFD6 (-42), exception=0, data_resultRDY exactly 34 cycles after the pulse edge, one cycle wide.
REQ-033 MULT 0x00010000 x 0x00010000 -> data_result=0x00000000, exception=1.
REQ-034 DIV -7 / 2 -> data_result=0xFFFFFFFD (-3), exception=0; DIV 100 / 0 -> data_result=0, exception=1.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> data_result=0x80000000, exception=1.
REQ-036 ctrl_DIV pulsed at cycle 10 of a running MULT 3 x 5 -> ignored, data_result=15; both ctrl lines high in IDLE -> busy stays 0 and no data_resultRDY pulse.
REQ-037 reset asserted at iteration 16, then MULT 2 x 3 -> no strobe for the aborted operation; second operation returns 6 after 34 cycles.
